player_ship_ctrl: RTL
=====================

Name: player_ship_ctrl

Overview:
- Parametrised next-generation player controller for the space-invaders datapath.
- Decodes held keyboard keys, moves the ship once per frame with configurable speed and screen bounds, and manages lives through an ALIVE/INVULN/DEAD state machine with a blink window.
- Issues missile launch requests over a req/ack handshake with a frame-based cooldown.
- Outputs the ship position to the square/bitmap drawing chain and a visibility flag to the draw mux.

Parameters:
- KEYCODE_WIDTH, 9: keyboard code width.
- KEY_UP / KEY_DOWN / KEY_LEFT / KEY_RIGHT / KEY_FIRE, 9'h075 / 9'h073 / 9'h06B / 9'h074 / 9'h029: key bindings.
- OBJ_W, 32: ship width in pixels.
- OBJ_H, 32: ship height in pixels.
- X_MIN, 0 and X_MAX, 639: legal pixel range for X; the right edge is clamped at X_MAX-OBJ_W+1.
- Y_MIN, 240 and Y_MAX, 479: legal pixel range for Y, clamped the same way.
- START_X, 304 and START_Y, 440: spawn top-left corner.
- SPEED, 2: pixels moved per frame per axis.
- LIVES, 3: starting lives (1..7).
- INVULN_FRAMES, 120: post-hit invulnerability length in frames.
- BLINK_FRAMES, 8: visibility toggle period during INVULN.
- COOLDOWN_FRAMES, 15: frames between missile launches.

Ports:
- clk  in  1  system clock
- resetN  in  1  synchronous reset, active-high (1 = reset)
- keyCode  in  KEYCODE_WIDTH  scan code, valid when make or brake
- make  in  1  key-press pulse
- brake  in  1  key-release pulse
- startOfFrame  in  1  one-cycle frame strobe
- hit  in  1  ship collided with an enemy or enemy missile (pulse)
- restart  in  1  new-game pulse
- fire_ack  in  1  missile block accepted the request
- topLeftX  out  11 signed  ship X
- topLeftY  out  11 signed  ship Y
- visible  out  1  ship should be drawn
- alive  out  1  state != DEAD
- lives  out  3  remaining lives
- fire_req  out  1  launch request
- fire_x  out  11 signed  launch X = topLeftX + OBJ_W/2
- fire_y  out  11 signed  launch Y = topLeftY

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Port names are clk and resetN; resetN=1 sampled on a clk edge resets the block.
- Reset values: topLeftX=START_X, topLeftY=START_Y, state=ALIVE, lives=LIVES, visible=1, alive=1, fire_req=0, cooldown=0, all key-held flags=0.
  - Reset mid-handshake drops fire_req immediately.
- Key decode (five instances of sub-module):
  - make with a matching code sets the held flag on the next edge; brake with a matching code clears it.
  - If make and brake arrive in the same cycle, brake wins.
- Movement happens only on the startOfFrame cycle and only in ALIVE or INVULN.
  - dx = SPEED*(right-left); left+right together gives dx=0. dy is computed the same way from down/up.
  - Sums use 12-bit signed intermediates, then clamp to [X_MIN, X_MAX-OBJ_W+1] and [Y_MIN, Y_MAX-OBJ_H+1]. Position registers update one cycle after the strobe.
- State machine:
  - ALIVE: hit with lives>1 → lives-1, INVULN, frame counter=0. Hit with lives==1 → lives=0, DEAD.
  - INVULN: hit is ignored. Counter increments each startOfFrame; visible toggles when counter%BLINK_FRAMES==BLINK_FRAMES-1. At counter==INVULN_FRAMES-1 → ALIVE, visible=1.
  - DEAD: visible=0, alive=0, no movement, no fire, hit ignored.
  - restart (any state, except during reset) → ALIVE, lives=LIVES, position=START, cooldown=0, fire_req=0. restart takes priority over hit in the same cycle.
- Fire handshake:
  - Cooldown decrements on each startOfFrame while nonzero.
  - If fire is held, cooldown==0, state!=DEAD and fire_req==0, then fire_req=1 on the next edge. fire_x and fire_y are latched at that edge and held stable while fire_req=1.
  - fire_req stays high until fire_ack is sampled high. On that edge fire_req=0 and cooldown=COOLDOWN_FRAMES.
  - fire_ack while fire_req=0 is ignored.
  - Entering DEAD drops fire_req.
- Latency summary: key→held flag 1 cycle; strobe→position 1 cycle; hit→lives/state 1 cycle.

Decomposition:
- Package player_pkg holds:
  - typedef enum logic [1:0] {ALIVE, INVULN, DEAD} ship_state_t;
  - default key-code constants;
  - localparam COORD_W=11.
- One sub-module: key_hold_decoder, with parameter KEY_VALUE and ports clk, resetN, keyCode, make, brake → held.
- Clamp arithmetic is a package function clamp_coord(value, lo, hi).

Test Plan:
- Reset, then 5 frames with RIGHT held → topLeftX=304+10=314, topLeftY=440; visible=1, lives=3.
- LEFT held for 200 frames from X=304 → topLeftX reaches 0 and stays 0. Holding LEFT+RIGHT together gives no change.
- Single hit pulse in ALIVE → lives=2, INVULN. visible toggles after frames 8, 16, …; a second hit at frame 30 leaves lives=2. After frame 120 the state is ALIVE and visible=1.
- Three hits separated by >120 frames → lives=0, alive=0, visible=0. Movement keys and FIRE are then ignored; restart → lives=3, X=304, Y=440, alive=1.
- FIRE held at X=304,Y=440 → fire_req=1 with fire_x=320, fire_y=440. Hold fire_ack=0 for 10 cycles → fire_req stays 1 with stable coordinates. Pulse fire_ack → fire_req=0; no new request for 15 frames, then a new request appears.
- make and brake for KEY_UP in the same cycle → up flag stays 0. resetN=1 during a pending fire_req → fire_req=0 and position returns to START on the next edge.

Source files
------------

// File: rtl/player_ship_ctrl_pkg.sv
// rtl/player_ship_ctrl_pkg.sv - shared types, constants and clamp helper for the player ship
// Purpose: ship state encoding, default key bindings, coordinate width and
//          the saturating clamp used by the movement datapath.
// Ports:   none (package).
package player_pkg;

  localparam int COORD_W = 11;

  localparam logic [8:0] KEY_UP_DEF    = 9'h075;
  localparam logic [8:0] KEY_DOWN_DEF  = 9'h073;
  localparam logic [8:0] KEY_LEFT_DEF  = 9'h06B;
  localparam logic [8:0] KEY_RIGHT_DEF = 9'h074;
  localparam logic [8:0] KEY_FIRE_DEF  = 9'h029;

  typedef enum logic [1:0] {ALIVE, INVULN, DEAD} ship_state_t;

  // Takes the one-bit-wider signed sum so an underflow past zero is seen as
  // negative rather than wrapping to a large positive coordinate.
  function automatic logic signed [COORD_W-1:0] clamp_coord(
    input logic signed [COORD_W:0] value,
    input logic signed [COORD_W:0] lo,
    input logic signed [COORD_W:0] hi
  );
    logic signed [COORD_W:0] r;
    if (value < lo)      r = lo;
    else if (value > hi) r = hi;
    else                 r = value;
    return r[COORD_W-1:0];
  endfunction

endpackage

// File: rtl/player_ship_ctrl_if.sv
// rtl/player_ship_ctrl_if.sv - missile launch req/ack handshake bundle
// Purpose: carries the launch request and launch coordinates to the missile
//          block and its acknowledge back.
// Signals: fire_req (master->slave), fire_x/fire_y (master->slave, stable
//          while fire_req), fire_ack (slave->master).
interface player_ship_ctrl_if;
  import player_pkg::*;

  logic                      fire_req;
  logic                      fire_ack;
  logic signed [COORD_W-1:0] fire_x;
  logic signed [COORD_W-1:0] fire_y;

  modport master (output fire_req, output fire_x, output fire_y, input fire_ack);
  modport slave  (input fire_req, input fire_x, input fire_y, output fire_ack);
endinterface

// File: rtl/player_ship_ctrl_key_hold_decoder.sv
// rtl/player_ship_ctrl_key_hold_decoder.sv - held-key flag for one scan code
// Purpose: tracks whether the key KEY_VALUE is currently held down.
// Ports:   clk, resetN (sync, active-high), keyCode/make/brake (keyboard
//          events), held (flag, updates one edge after the event).
module key_hold_decoder
  import player_pkg::*;
#(
  parameter int                       KEYCODE_WIDTH = 9,
  parameter logic [KEYCODE_WIDTH-1:0] KEY_VALUE     = KEY_UP_DEF
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic [KEYCODE_WIDTH-1:0] keyCode,
  input  logic                     make,
  input  logic                     brake,
  output logic                     held
);

  logic w_match;
  logic r_held;

  assign w_match = (keyCode == KEY_VALUE);

  // Release is checked first so a simultaneous make+brake leaves the key up.
  always_ff @(posedge clk) begin
    if (resetN)                  r_held <= 1'b0;
    else if (brake && w_match)   r_held <= 1'b0;
    else if (make && w_match)    r_held <= 1'b1;
  end

  assign held = r_held;

endmodule

// File: rtl/player_ship_ctrl.sv
// rtl/player_ship_ctrl.sv - player ship movement, lives FSM and missile launch
// Purpose: moves the ship once per frame from held keys, runs the
//          ALIVE/INVULN/DEAD lives machine with blinking, and requests
//          missile launches with a frame cooldown.
// Ports:   clk, resetN (sync, active-high); keyCode/make/brake keyboard;
//          startOfFrame strobe; hit, restart pulses; fire_bus (req/ack
//          master); topLeftX/topLeftY position; visible, alive, lives.
module player_ship_ctrl
  import player_pkg::*;
#(
  parameter int                       KEYCODE_WIDTH   = 9,
  parameter logic [KEYCODE_WIDTH-1:0] KEY_UP          = KEY_UP_DEF,
  parameter logic [KEYCODE_WIDTH-1:0] KEY_DOWN        = KEY_DOWN_DEF,
  parameter logic [KEYCODE_WIDTH-1:0] KEY_LEFT        = KEY_LEFT_DEF,
  parameter logic [KEYCODE_WIDTH-1:0] KEY_RIGHT       = KEY_RIGHT_DEF,
  parameter logic [KEYCODE_WIDTH-1:0] KEY_FIRE        = KEY_FIRE_DEF,
  parameter int                       OBJ_W           = 32,
  parameter int                       OBJ_H           = 32,
  parameter int                       X_MIN           = 0,
  parameter int                       X_MAX           = 639,
  parameter int                       Y_MIN           = 240,
  parameter int                       Y_MAX           = 479,
  parameter int                       START_X         = 304,
  parameter int                       START_Y         = 440,
  parameter int                       SPEED           = 2,
  parameter int                       LIVES           = 3,
  parameter int                       INVULN_FRAMES   = 120,
  parameter int                       BLINK_FRAMES    = 8,
  parameter int                       COOLDOWN_FRAMES = 15
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [KEYCODE_WIDTH-1:0]  keyCode,
  input  logic                      make,
  input  logic                      brake,
  input  logic                      startOfFrame,
  input  logic                      hit,
  input  logic                      restart,
  player_ship_ctrl_if.master        fire_bus,
  output logic signed [COORD_W-1:0] topLeftX,
  output logic signed [COORD_W-1:0] topLeftY,
  output logic                      visible,
  output logic                      alive,
  output logic [2:0]                lives
);

  localparam int CNT_W  = $clog2(INVULN_FRAMES + 1);
  localparam int CD_W   = $clog2(COOLDOWN_FRAMES + 1);
  localparam int XHI_I  = X_MAX - OBJ_W + 1;
  localparam int YHI_I  = Y_MAX - OBJ_H + 1;
  localparam int HALF_I = OBJ_W / 2;

  localparam logic signed [COORD_W:0]   LP_X_LO    = X_MIN[COORD_W:0];
  localparam logic signed [COORD_W:0]   LP_X_HI    = XHI_I[COORD_W:0];
  localparam logic signed [COORD_W:0]   LP_Y_LO    = Y_MIN[COORD_W:0];
  localparam logic signed [COORD_W:0]   LP_Y_HI    = YHI_I[COORD_W:0];
  localparam logic signed [COORD_W:0]   LP_SPEED   = SPEED[COORD_W:0];
  localparam logic signed [COORD_W-1:0] LP_START_X = START_X[COORD_W-1:0];
  localparam logic signed [COORD_W-1:0] LP_START_Y = START_Y[COORD_W-1:0];
  localparam logic signed [COORD_W-1:0] LP_HALF_W  = HALF_I[COORD_W-1:0];
  localparam logic [2:0]                LP_LIVES   = LIVES[2:0];
  localparam logic [CNT_W-1:0] LP_INV_LAST   = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [CNT_W-1:0] LP_BLINK      = CNT_W'(BLINK_FRAMES);
  localparam logic [CNT_W-1:0] LP_BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CD_W-1:0]  LP_COOLDOWN   = CD_W'(COOLDOWN_FRAMES);

  logic w_up, w_down, w_left, w_right, w_fire;

  key_hold_decoder #(.KEYCODE_WIDTH(KEYCODE_WIDTH), .KEY_VALUE(KEY_UP)) u_key_up (
    .clk(clk), .resetN(resetN), .keyCode(keyCode), .make(make), .brake(brake), .held(w_up));
  key_hold_decoder #(.KEYCODE_WIDTH(KEYCODE_WIDTH), .KEY_VALUE(KEY_DOWN)) u_key_down (
    .clk(clk), .resetN(resetN), .keyCode(keyCode), .make(make), .brake(brake), .held(w_down));
  key_hold_decoder #(.KEYCODE_WIDTH(KEYCODE_WIDTH), .KEY_VALUE(KEY_LEFT)) u_key_left (
    .clk(clk), .resetN(resetN), .keyCode(keyCode), .make(make), .brake(brake), .held(w_left));
  key_hold_decoder #(.KEYCODE_WIDTH(KEYCODE_WIDTH), .KEY_VALUE(KEY_RIGHT)) u_key_right (
    .clk(clk), .resetN(resetN), .keyCode(keyCode), .make(make), .brake(brake), .held(w_right));
  key_hold_decoder #(.KEYCODE_WIDTH(KEYCODE_WIDTH), .KEY_VALUE(KEY_FIRE)) u_key_fire (
    .clk(clk), .resetN(resetN), .keyCode(keyCode), .make(make), .brake(brake), .held(w_fire));

  ship_state_t               r_state, n_state;
  logic [2:0]                r_lives, n_lives;
  logic [CNT_W-1:0]          r_cnt, n_cnt;
  logic                      r_visible, n_visible;
  logic signed [COORD_W-1:0] r_x, n_x, r_y, n_y;
  logic signed [COORD_W-1:0] r_fx, n_fx, r_fy, n_fy;
  logic                      r_req, n_req;
  logic [CD_W-1:0]           r_cd, n_cd;
  logic signed [COORD_W:0]   w_dx, w_dy, w_sum_x, w_sum_y;

  // Opposite keys cancel to zero motion on that axis.
  always_comb begin
    w_dx = '0;
    w_dy = '0;
    if (w_right && !w_left)      w_dx = LP_SPEED;
    else if (w_left && !w_right) w_dx = -LP_SPEED;
    if (w_down && !w_up)         w_dy = LP_SPEED;
    else if (w_up && !w_down)    w_dy = -LP_SPEED;
  end

  assign w_sum_x = {r_x[COORD_W-1], r_x} + w_dx;
  assign w_sum_y = {r_y[COORD_W-1], r_y} + w_dy;

  always_ff @(posedge clk) begin
    if (resetN) begin
      r_state   <= ALIVE;
      r_lives   <= LP_LIVES;
      r_cnt     <= '0;
      r_visible <= 1'b1;
      r_x       <= LP_START_X;
      r_y       <= LP_START_Y;
      r_fx      <= '0;
      r_fy      <= '0;
      r_req     <= 1'b0;
      r_cd      <= '0;
    end else begin
      r_state   <= n_state;
      r_lives   <= n_lives;
      r_cnt     <= n_cnt;
      r_visible <= n_visible;
      r_x       <= n_x;
      r_y       <= n_y;
      r_fx      <= n_fx;
      r_fy      <= n_fy;
      r_req     <= n_req;
      r_cd      <= n_cd;
    end
  end

  always_comb begin
    n_state   = r_state;
    n_lives   = r_lives;
    n_cnt     = r_cnt;
    n_visible = r_visible;
    n_x       = r_x;
    n_y       = r_y;
    n_fx      = r_fx;
    n_fy      = r_fy;
    n_req     = r_req;
    n_cd      = r_cd;

    if (startOfFrame && (r_cd != '0)) n_cd = r_cd - CD_W'(1);

    if (startOfFrame && (r_state != DEAD)) begin
      n_x = clamp_coord(w_sum_x, LP_X_LO, LP_X_HI);
      n_y = clamp_coord(w_sum_y, LP_Y_LO, LP_Y_HI);
    end

    // Launch coordinates are captured with the request and frozen until ack.
    if (r_req && fire_bus.fire_ack) begin
      n_req = 1'b0;
      n_cd  = LP_COOLDOWN;
    end else if (!r_req && w_fire && (r_cd == '0) && (r_state != DEAD)) begin
      n_req = 1'b1;
      n_fx  = r_x + LP_HALF_W;
      n_fy  = r_y;
    end

    unique case (r_state)
      ALIVE: begin
        if (hit) begin
          if (r_lives > 3'd1) begin
            n_lives = r_lives - 3'd1;
            n_state = INVULN;
            n_cnt   = '0;
          end else begin
            n_lives   = 3'd0;
            n_state   = DEAD;
            n_visible = 1'b0;
            n_req     = 1'b0;
          end
        end
      end
      INVULN: begin
        if (startOfFrame) begin
          n_cnt = r_cnt + CNT_W'(1);
          if (r_cnt == LP_INV_LAST) begin
            n_state   = ALIVE;
            n_visible = 1'b1;
            n_cnt     = '0;
          end else if ((r_cnt % LP_BLINK) == LP_BLINK_LAST) begin
            n_visible = ~r_visible;
          end
        end
      end
      default: begin
        n_visible = 1'b0;
        n_req     = 1'b0;
      end
    endcase

    // New game overrides everything else in the same cycle, including hit.
    if (restart) begin
      n_state   = ALIVE;
      n_lives   = LP_LIVES;
      n_cnt     = '0;
      n_visible = 1'b1;
      n_x       = LP_START_X;
      n_y       = LP_START_Y;
      n_req     = 1'b0;
      n_cd      = '0;
    end
  end

  assign topLeftX          = r_x;
  assign topLeftY          = r_y;
  assign visible           = r_visible;
  assign alive             = (r_state != DEAD);
  assign lives             = r_lives;
  assign fire_bus.fire_req = r_req;
  assign fire_bus.fire_x   = r_fx;
  assign fire_bus.fire_y   = r_fy;

endmodule
